// File: rtl/h264vlcarb.sv
// h264vlcarb: shares the byte packer port between header, coefficient and slice-end alignment words.
module h264vlcarb #(
  parameter int CNTW = 32
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            HVALID,
  input  logic [19:0]     HVE,
  input  logic [4:0]      HVL,
  input  logic            HLAST,
  output logic            HREADY,
  input  logic            CVALID,
  input  logic [24:0]     CVE,
  input  logic [4:0]      CVL,
  input  logic            CLAST,
  output logic            CREADY,
  input  logic            ALIGN,
  output logic            VALID,
  output logic [24:0]     VE,
  output logic [4:0]      VL,
  input  logic            READY,
  output logic [CNTW-1:0] BITCOUNT,
  output logic            DONE,
  output logic            ERR
);
  typedef enum logic [1:0] {IDLE, HDR, COEF, ALGN} state_t;
  state_t state_q, state_d;
  logic apend_q, apend_d, done_q, done_d, err_q, err_d, xfer;
  logic [2:0] ab_q, ab_d;
  logic [4:0] avl;
  logic [CNTW-1:0] bc_q, bc_d;
  always_comb begin
    avl = 5'd8 - {2'b00, ab_q};
    VALID = state_q == HDR ? HVALID : state_q == COEF ? CVALID : state_q == ALGN;
    VE = state_q == HDR ? {5'b0, HVE} : state_q == COEF ? CVE :
         state_q == ALGN ? 25'd1 << (avl - 5'd1) : '0;
    VL = state_q == HDR ? HVL : state_q == COEF ? CVL : state_q == ALGN ? avl : '0;
    HREADY = state_q == HDR && READY;
    CREADY = state_q == COEF && READY;
    xfer = VALID && READY;
    state_d = state_q;
    case (state_q)
      IDLE: state_d = (apend_q || ALIGN) ? ALGN : HVALID ? HDR : IDLE;
      HDR:  state_d = (xfer && HLAST) ? COEF : HDR;
      COEF: state_d = (xfer && CLAST) ? IDLE : COEF;
      ALGN: state_d = xfer ? IDLE : ALGN;
      default: state_d = IDLE;
    endcase
    // the low bits of the count are frozen while idle, so sampling here gives the entry value
    ab_d = state_q == IDLE ? bc_q[2:0] : ab_q;
    apend_d = ALIGN || (apend_q && !(state_q == ALGN && xfer));
    done_d = state_q == ALGN && xfer;
    bc_d = bc_q + (xfer ? CNTW'(VL) : '0);
    err_d = err_q || (state_q == IDLE && CVALID) ||
            (xfer && state_q == HDR && HVL > 5'd20) ||
            (xfer && state_q == COEF && CVL > 5'd25);
    BITCOUNT = bc_q;
    DONE = done_q;
    ERR = err_q;
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      apend_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      ab_q <= '0;
      bc_q <= '0;
    end else begin
      state_q <= state_d;
      apend_q <= apend_d;
      done_q <= done_d;
      err_q <= err_d;
      ab_q <= ab_d;
      bc_q <= bc_d;
    end
  end
endmodule

// File: tb/tb_h264vlcarb.sv
// tb_h264vlcarb: directed cycle tables plus randomized macroblock traffic against a word-stream model.
module tb_h264vlcarb;
  logic CLK = 0, RESET, HVALID, HLAST, CVALID, CLAST, ALIGN, READY;
  logic HREADY, CREADY, VALID, DONE, ERR;
  logic [19:0] HVE;
  logic [4:0] HVL, CVL, VL;
  logic [24:0] CVE, VE;
  logic [31:0] BITCOUNT;
  int tests = 0, fails = 0;

  h264vlcarb #(.CNTW(32)) dut (
    .CLK(CLK), .RESET(RESET), .HVALID(HVALID), .HVE(HVE), .HVL(HVL), .HLAST(HLAST),
    .HREADY(HREADY), .CVALID(CVALID), .CVE(CVE), .CVL(CVL), .CLAST(CLAST),
    .CREADY(CREADY), .ALIGN(ALIGN), .VALID(VALID), .VE(VE), .VL(VL), .READY(READY),
    .BITCOUNT(BITCOUNT), .DONE(DONE), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic rst, hv; logic [19:0] hve; logic [4:0] hvl; logic hl;
    logic cv; logic [24:0] cve; logic [4:0] cvl; logic cl; logic al, rdy;
    logic ev; logic [24:0] eve; logic [4:0] evl; logic ehr, ecr;
    logic [31:0] ebc; logic edone, eerr;
  } vec_t;

  typedef struct { logic [24:0] ve; logic [4:0] vl; logic last; } w_t;

  vec_t tbl[$], seq[$];
  w_t hq[$], cq[$];
  logic [29:0] exp_q[$];

  function automatic vec_t row(logic rst, logic hv, logic [19:0] hve, logic [4:0] hvl, logic hl,
                               logic cv, logic [24:0] cve, logic [4:0] cvl, logic cl, logic al,
                               logic rdy, logic ev, logic [24:0] eve, logic [4:0] evl, logic ehr,
                               logic ecr, logic [31:0] ebc, logic edone, logic eerr);
    vec_t v;
    v.rst = rst; v.hv = hv; v.hve = hve; v.hvl = hvl; v.hl = hl;
    v.cv = cv; v.cve = cve; v.cvl = cvl; v.cl = cl; v.al = al; v.rdy = rdy;
    v.ev = ev; v.eve = eve; v.evl = evl; v.ehr = ehr; v.ecr = ecr;
    v.ebc = ebc; v.edone = edone; v.eerr = eerr;
    return v;
  endfunction

  function automatic w_t mkw(int maxl, logic last);
    w_t w;
    logic [25:0] mask;
    w.vl = 5'($urandom_range(maxl, 0));
    mask = (26'd1 << w.vl) - 26'd1;
    w.ve = 25'($urandom) & mask[24:0];
    w.last = last;
    return w;
  endfunction

  task automatic idle_inputs();
    HVALID = 0; HVE = 0; HVL = 0; HLAST = 0;
    CVALID = 0; CVE = 0; CVL = 0; CLAST = 0;
    ALIGN = 0; READY = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    RESET = 1;
    repeat (2) @(posedge CLK);
    #1 RESET = 0;
  endtask

  task automatic apply(input string name, input int idx, input vec_t v);
    logic [66:0] act, exp;
    RESET = v.rst; HVALID = v.hv; HVE = v.hve; HVL = v.hvl; HLAST = v.hl;
    CVALID = v.cv; CVE = v.cve; CVL = v.cvl; CLAST = v.cl; ALIGN = v.al; READY = v.rdy;
    @(negedge CLK);
    act = {VALID, VE, VL, HREADY, CREADY, BITCOUNT, DONE, ERR};
    exp = {v.ev, v.eve, v.evl, v.ehr, v.ecr, v.ebc, v.edone, v.eerr};
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d]: got valid=%b ve=%h vl=%0d hr=%b cr=%b bc=%0d done=%b err=%b, want valid=%b ve=%h vl=%0d hr=%b cr=%b bc=%0d done=%b err=%b",
               name, idx, VALID, VE, VL, HREADY, CREADY, BITCOUNT, DONE, ERR,
               v.ev, v.eve, v.evl, v.ehr, v.ecr, v.ebc, v.edone, v.eerr);
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  initial begin
    int unsigned sum;
    int cyc, nh, nc;
    logic al, first;
    logic [4:0] avl;
    logic [29:0] e;
    do_reset();
    for (int i = 0; i < 10; i++)
      apply("idle", i, row(0,0,0,0,0, 0,0,0,0, 0,0, 0,0,0,0,0, 0,0,0));

    tbl.push_back(row(0,1,'h15,5,0, 0,0,0,0, 0,1, 0,0,0,0,0, 0,0,0));
    tbl.push_back(row(0,1,'h15,5,0, 0,0,0,0, 0,1, 1,'h15,5,1,0, 0,0,0));
    tbl.push_back(row(0,1,'h5A,7,1, 0,0,0,0, 0,1, 1,'h5A,7,1,0, 5,0,0));
    tbl.push_back(row(0,0,0,0,0, 1,'h5,3,0, 0,1, 1,'h5,3,0,1, 12,0,0));
    tbl.push_back(row(0,0,0,0,0, 1,'h1A3,9,0, 0,1, 1,'h1A3,9,0,1, 15,0,0));
    tbl.push_back(row(0,0,0,0,0, 1,'hB,4,1, 0,1, 1,'hB,4,0,1, 24,0,0));
    tbl.push_back(row(0,0,0,0,0, 0,0,0,0, 0,1, 0,0,0,0,0, 28,0,0));
    tbl.push_back(row(0,0,0,0,0, 0,0,0,0, 1,1, 0,0,0,0,0, 28,0,0));
    tbl.push_back(row(0,0,0,0,0, 0,0,0,0, 0,1, 1,'h8,4,0,0, 28,0,0));
    tbl.push_back(row(0,0,0,0,0, 0,0,0,0, 0,1, 0,0,0,0,0, 32,1,0));
    tbl.push_back(row(0,0,0,0,0, 0,0,0,0, 1,1, 0,0,0,0,0, 32,0,0));
    tbl.push_back(row(0,0,0,0,0, 0,0,0,0, 0,0, 1,'h80,8,0,0, 32,0,0));
    tbl.push_back(row(0,0,0,0,0, 0,0,0,0, 0,1, 1,'h80,8,0,0, 32,0,0));
    tbl.push_back(row(0,0,0,0,0, 0,0,0,0, 0,1, 0,0,0,0,0, 40,1,0));
    foreach (tbl[i]) apply("table", i, tbl[i]);

    do_reset();
    sum = 0;
    cyc = 0;
    for (int m = 0; m < 40; m++) begin
      hq.delete();
      cq.delete();
      nh = $urandom_range(3, 1);
      nc = $urandom_range(4, 1);
      for (int i = 0; i < nh; i++) hq.push_back(mkw(20, i == nh - 1));
      for (int i = 0; i < nc; i++) cq.push_back(mkw(25, i == nc - 1));
      al = $urandom_range(2, 0) == 0;
      if (al) begin
        avl = 5'(8 - (sum % 8));
        exp_q.push_back({25'd1 << (avl - 5'd1), avl});
        sum += avl;
      end
      foreach (hq[i]) begin exp_q.push_back({hq[i].ve, hq[i].vl}); sum += hq[i].vl; end
      foreach (cq[i]) begin exp_q.push_back({cq[i].ve, cq[i].vl}); sum += cq[i].vl; end
      first = 1;
      while ((hq.size() > 0 || cq.size() > 0) && cyc < 30000) begin
        HVALID = hq.size() > 0 && $urandom_range(3, 0) != 0;
        HVE = hq.size() > 0 ? hq[0].ve[19:0] : '0;
        HVL = hq.size() > 0 ? hq[0].vl : '0;
        HLAST = hq.size() > 0 ? hq[0].last : 1'b0;
        CVALID = hq.size() == 0 && cq.size() > 0 && $urandom_range(3, 0) != 0;
        CVE = cq.size() > 0 ? cq[0].ve : '0;
        CVL = cq.size() > 0 ? cq[0].vl : '0;
        CLAST = cq.size() > 0 ? cq[0].last : 1'b0;
        ALIGN = first && al;
        first = 0;
        READY = $urandom_range(3, 0) != 0;
        @(negedge CLK);
        if (VALID && READY) begin
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL rand_xfer: got unexpected ve=%h vl=%0d, want no transfer", VE, VL);
          end else begin
            e = exp_q.pop_front();
            if ({VE, VL} !== e) begin
              fails++;
              $display("FAIL rand_xfer: got ve=%h vl=%0d, want ve=%h vl=%0d", VE, VL, e[29:5], e[4:0]);
            end
          end
        end
        if (HVALID && HREADY) void'(hq.pop_front());
        if (CVALID && CREADY) void'(cq.pop_front());
        @(posedge CLK);
        #1 cyc++;
      end
    end
    idle_inputs();
    repeat (3) @(posedge CLK);
    #1;
    check("rand_pending_words", exp_q.size(), 0);
    check("rand_bitcount", BITCOUNT, sum);
    check("rand_err", {31'd0, ERR}, 0);

    do_reset();
    seq.push_back(row(0,1,3,2,1, 0,0,0,0, 0,1, 0,0,0,0,0, 0,0,0));
    seq.push_back(row(0,1,3,2,1, 0,0,0,0, 0,1, 1,3,2,1,0, 0,0,0));
    seq.push_back(row(0,0,0,0,0, 1,5,3,0, 1,1, 1,5,3,0,1, 2,0,0));
    seq.push_back(row(0,0,0,0,0, 1,1,1,1, 0,1, 1,1,1,0,1, 5,0,0));
    seq.push_back(row(0,0,0,0,0, 0,0,0,0, 0,1, 0,0,0,0,0, 6,0,0));
    seq.push_back(row(0,0,0,0,0, 0,0,0,0, 0,1, 1,2,2,0,0, 6,0,0));
    seq.push_back(row(0,0,0,0,0, 0,0,0,0, 0,1, 0,0,0,0,0, 8,1,0));
    seq.push_back(row(0,0,0,0,0, 1,7,3,0, 0,1, 0,0,0,0,0, 8,0,0));
    seq.push_back(row(0,0,0,0,0, 0,0,0,0, 0,1, 0,0,0,0,0, 8,0,1));
    seq.push_back(row(0,0,0,0,0, 0,0,0,0, 0,1, 0,0,0,0,0, 8,0,1));
    seq.push_back(row(0,1,9,4,1, 0,0,0,0, 0,1, 0,0,0,0,0, 8,0,1));
    seq.push_back(row(0,1,9,4,1, 0,0,0,0, 0,1, 1,9,4,1,0, 8,0,1));
    seq.push_back(row(1,0,0,0,0, 1,'h1F,5,0, 0,0, 1,'h1F,5,0,0, 12,0,1));
    seq.push_back(row(0,0,0,0,0, 0,0,0,0, 0,0, 0,0,0,0,0, 0,0,0));
    foreach (seq[i]) apply("corner", i, seq[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
